// File: rtl/ctrl_pkt_gen.sv
// ---------------------------------------------------------------------------
// ctrl_pkt_gen
//   Control-path packet generator at the transmit end of the pipeline.
//   Each accepted table-write request becomes one AXI-Stream control packet:
//   a header beat followed by 1..4 payload beats. The stream has no tready,
//   so a packet runs back-to-back to completion. After each packet a fixed
//   inter-packet gap of IPG_CYCLES idle cycles is inserted.
//
//   Optional feature macro: CTRL_GEN_SEQNUM_EN
//     defined   -> 8-bit sequence number in header tdata[39:32], +1 per packet
//     undefined -> header tdata[39:32] = 0, no counter built
//
// Ports
//   axis_clk         clock
//   areset           synchronous reset, active-high
//   req_valid/ready  write-request handshake (ready only while idle)
//   req_stage_id     target stage (5b)
//   req_mod_id       target module within stage (3b)
//   req_index        table entry index (8b)
//   req_nbeats       payload beats minus 1 (2b)
//   req_data         payload, beat k = slice k (LSB slice first)
//   c_m_axis_*       control stream out (tdata/tuser/tkeep/tvalid/tlast)
//   busy             generator not idle
//   pkt_cnt          completed packets, wraps
// ---------------------------------------------------------------------------
module ctrl_pkt_gen #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 256,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter int          MAX_BEATS            = 4,
  parameter logic [15:0] CTRL_MAGIC           = 16'hF2F1,
  parameter int          IPG_CYCLES           = 2
) (
  input  logic                                 axis_clk,
  input  logic                                 areset,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [4:0]                           req_stage_id,
  input  logic [2:0]                           req_mod_id,
  input  logic [7:0]                           req_index,
  input  logic [1:0]                           req_nbeats,
  input  logic [C_S_AXIS_DATA_WIDTH*4-1:0]     req_data,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
  output logic                                 c_m_axis_tvalid,
  output logic                                 c_m_axis_tlast,
  output logic                                 busy,
  output logic [15:0]                          pkt_cnt
);

  localparam int         LP_W        = C_S_AXIS_DATA_WIDTH;
  localparam int         LP_BYTES    = C_S_AXIS_DATA_WIDTH / 8;
  localparam logic [1:0] LP_NB_MAX   = 2'(MAX_BEATS - 1);
  localparam logic [3:0] LP_GAP_LOAD = (IPG_CYCLES > 0) ? 4'(IPG_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_GAP
  } state_t;

  state_t               r_state;
  logic [1:0]           r_nbeats;
  logic [1:0]           r_beat;
  logic [3:0]           r_gap;
  logic [4*LP_W-1:0]    r_data;

  logic [1:0]                      w_nbeats;
  logic [1:0]                      w_next_beat;
  logic [7:0]                      w_seq;
  logic [LP_W-1:0]                 w_hdr;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] w_tuser;
  logic                            w_last_beat;

`ifdef CTRL_GEN_SEQNUM_EN
  logic [7:0] r_seq;

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      r_seq <= '0;
    end else if (r_state == ST_PAYLOAD && w_last_beat) begin
      r_seq <= r_seq + 8'd1;
    end
  end

  assign w_seq = r_seq;
`else
  assign w_seq = '0;
`endif

  always_comb begin
    // Oversized requests are clamped; with MAX_BEATS=4 this never triggers.
    w_nbeats = req_nbeats;
    if (req_nbeats > LP_NB_MAX) begin
      w_nbeats = LP_NB_MAX;
    end

    w_hdr        = '0;
    w_hdr[15:0]  = CTRL_MAGIC;
    w_hdr[23:16] = {req_stage_id, req_mod_id};
    w_hdr[31:24] = req_index;
    w_hdr[39:32] = w_seq;

    w_tuser       = '0;
    w_tuser[15:0] = 16'(LP_BYTES * (int'(w_nbeats) + 2));

    w_next_beat = r_beat + 2'd1;
    w_last_beat = (r_beat == r_nbeats);
  end

  // r_state names the beat currently on the output registers: ST_HDR while
  // the header is driven, ST_PAYLOAD while payload slice r_beat is driven.
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      r_state         <= ST_IDLE;
      r_nbeats        <= '0;
      r_beat          <= '0;
      r_gap           <= '0;
      r_data          <= '0;
      c_m_axis_tdata  <= '0;
      c_m_axis_tuser  <= '0;
      c_m_axis_tkeep  <= '0;
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tlast  <= 1'b0;
      req_ready       <= 1'b1;
      busy            <= 1'b0;
      pkt_cnt         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            r_data          <= req_data;
            r_nbeats        <= w_nbeats;
            r_beat          <= '0;
            c_m_axis_tdata  <= w_hdr;
            c_m_axis_tuser  <= w_tuser;
            c_m_axis_tkeep  <= '1;
            c_m_axis_tvalid <= 1'b1;
            c_m_axis_tlast  <= 1'b0;
            req_ready       <= 1'b0;
            busy            <= 1'b1;
            r_state         <= ST_HDR;
          end
        end

        ST_HDR: begin
          c_m_axis_tdata <= r_data[0 +: LP_W];
          c_m_axis_tlast <= (r_nbeats == 2'd0);
          r_beat         <= '0;
          r_state        <= ST_PAYLOAD;
        end

        ST_PAYLOAD: begin
          if (w_last_beat) begin
            pkt_cnt         <= pkt_cnt + 16'd1;
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
            if (IPG_CYCLES > 0) begin
              r_gap   <= LP_GAP_LOAD;
              r_state <= ST_GAP;
            end else begin
              req_ready <= 1'b1;
              busy      <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end else begin
            r_beat         <= w_next_beat;
            c_m_axis_tdata <= r_data[int'(w_next_beat)*LP_W +: LP_W];
            c_m_axis_tlast <= (w_next_beat == r_nbeats);
          end
        end

        ST_GAP: begin
          if (r_gap == 4'd0) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
module tb_ctrl_pkt_gen;

  localparam int W   = 256;
  localparam int TU  = 128;
  localparam int KW  = W / 8;
  localparam int IPG = 2;

  logic            axis_clk = 1'b0;
  logic            areset   = 1'b1;

  logic            req_valid    = 1'b0;
  logic            req_ready;
  logic [4:0]      req_stage_id = '0;
  logic [2:0]      req_mod_id   = '0;
  logic [7:0]      req_index    = '0;
  logic [1:0]      req_nbeats   = '0;
  logic [4*W-1:0]  req_data     = '0;
  logic [W-1:0]    c_m_axis_tdata;
  logic [TU-1:0]   c_m_axis_tuser;
  logic [KW-1:0]   c_m_axis_tkeep;
  logic            c_m_axis_tvalid;
  logic            c_m_axis_tlast;
  logic            busy;
  logic [15:0]     pkt_cnt;

  // second instance: MAX_BEATS=2 (clamping) and IPG_CYCLES=0
  logic            r2_valid  = 1'b0;
  logic            r2_ready;
  logic [1:0]      r2_nbeats = '0;
  logic [4*W-1:0]  r2_data   = '0;
  logic [W-1:0]    o2_tdata;
  logic [TU-1:0]   o2_tuser;
  logic [KW-1:0]   o2_tkeep;
  logic            o2_tvalid;
  logic            o2_tlast;
  logic            o2_busy;
  logic [15:0]     o2_pkt_cnt;

  ctrl_pkt_gen #(
    .C_S_AXIS_DATA_WIDTH (W),
    .C_S_AXIS_TUSER_WIDTH(TU),
    .MAX_BEATS           (4),
    .CTRL_MAGIC          (16'hF2F1),
    .IPG_CYCLES          (IPG)
  ) u_dut (
    .axis_clk       (axis_clk),
    .areset         (areset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_stage_id   (req_stage_id),
    .req_mod_id     (req_mod_id),
    .req_index      (req_index),
    .req_nbeats     (req_nbeats),
    .req_data       (req_data),
    .c_m_axis_tdata (c_m_axis_tdata),
    .c_m_axis_tuser (c_m_axis_tuser),
    .c_m_axis_tkeep (c_m_axis_tkeep),
    .c_m_axis_tvalid(c_m_axis_tvalid),
    .c_m_axis_tlast (c_m_axis_tlast),
    .busy           (busy),
    .pkt_cnt        (pkt_cnt)
  );

  ctrl_pkt_gen #(
    .C_S_AXIS_DATA_WIDTH (W),
    .C_S_AXIS_TUSER_WIDTH(TU),
    .MAX_BEATS           (2),
    .CTRL_MAGIC          (16'hF2F1),
    .IPG_CYCLES          (0)
  ) u_dut2 (
    .axis_clk       (axis_clk),
    .areset         (areset),
    .req_valid      (r2_valid),
    .req_ready      (r2_ready),
    .req_stage_id   (5'd1),
    .req_mod_id     (3'd1),
    .req_index      (8'h33),
    .req_nbeats     (r2_nbeats),
    .req_data       (r2_data),
    .c_m_axis_tdata (o2_tdata),
    .c_m_axis_tuser (o2_tuser),
    .c_m_axis_tkeep (o2_tkeep),
    .c_m_axis_tvalid(o2_tvalid),
    .c_m_axis_tlast (o2_tlast),
    .busy           (o2_busy),
    .pkt_cnt        (o2_pkt_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  always @(posedge axis_clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   c;
    logic [W-1:0]  d;
    logic [TU-1:0] u;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  beat_t       beats[$];
  int unsigned n_tlast = 0;
  bit          rdy_log[int unsigned];

  // beat monitor, sampled mid-cycle
  always @(negedge axis_clk) begin
    rdy_log[cyc] = req_ready;
    if (c_m_axis_tvalid === 1'b1) begin
      beats.push_back('{cyc, c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast});
      if (c_m_axis_tlast === 1'b1) n_tlast++;
    end
  end

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  // Present one request on u_dut; returns with the handshake edge just passed.
  task automatic send(input logic [4:0] st, input logic [2:0] md, input logic [7:0] ix,
                      input logic [1:0] nb, input logic [4*W-1:0] dat,
                      output int unsigned hs_cyc);
    int unsigned t = 0;
    while (req_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (req_ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_ready_timeout: req_ready=%b required 1", req_ready);
    end
    req_stage_id = st;
    req_mod_id   = md;
    req_index    = ix;
    req_nbeats   = nb;
    req_data     = dat;
    req_valid    = 1'b1;
    hs_cyc       = cyc;
    tick();
    req_valid    = 1'b0;
  endtask

  task automatic wait_tlast(input int unsigned target);
    int unsigned t = 0;
    while (n_tlast < target && t < 60) begin
      tick();
      t++;
    end
    if (n_tlast < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL tlast_timeout: tlast count=%0d required %0d", n_tlast, target);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (c_m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b exp 0", c_m_axis_tvalid); end
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b exp 1", req_ready); end
    n_cmp++;
    if (pkt_cnt !== 16'd0) begin n_err++; $display("FAIL rst_pkt_cnt: got %0d exp 0", pkt_cnt); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_cmp++;
    if ({c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast} !== '0) begin
      n_err++;
      $display("FAIL rst_outputs_zero: tdata=%h tuser=%h tkeep=%h tlast=%b exp all 0",
               c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast);
    end
    areset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int unsigned    hs;
    logic [4*W-1:0] dat = '0;
    dat[W-1:0] = 256'hA5;
    beats.delete();
    send(5'd2, 3'd1, 8'h05, 2'd0, dat, hs);
    wait_tlast(n_tlast + 1);
    n_cmp++;
    if (beats.size() != 2) begin
      n_err++;
      $display("FAIL single_nbeats: got %0d beats exp 2", beats.size());
      return;
    end
    n_cmp++;
    if (beats[0].c != hs + 1) begin n_err++; $display("FAIL single_hdr_latency: got cyc %0d exp %0d", beats[0].c, hs + 1); end
    n_cmp++;
    if (beats[0].d[31:0] !== 32'h0511F2F1) begin n_err++; $display("FAIL single_hdr_low: got %h exp 0511f2f1", beats[0].d[31:0]); end
    n_cmp++;
    if (beats[0].d[W-1:32] !== '0) begin n_err++; $display("FAIL single_hdr_high: got %h exp 0", beats[0].d[W-1:32]); end
    n_cmp++;
    if (beats[0].u !== 128'd64) begin n_err++; $display("FAIL single_hdr_tuser: got %h exp 64", beats[0].u); end
    n_cmp++;
    if (beats[0].k !== {KW{1'b1}} || beats[0].l !== 1'b0) begin
      n_err++; $display("FAIL single_hdr_keep_last: tkeep=%h tlast=%b exp ffffffff/0", beats[0].k, beats[0].l);
    end
    n_cmp++;
    if (beats[1].d !== 256'hA5 || beats[1].l !== 1'b1) begin
      n_err++; $display("FAIL single_payload: tdata=%h tlast=%b exp a5/1", beats[1].d, beats[1].l);
    end
    n_cmp++;
    if (beats[1].c != hs + 2 || beats[1].u[15:0] !== 16'd64) begin
      n_err++; $display("FAIL single_payload_cyc_len: cyc=%0d len=%0d exp %0d/64", beats[1].c, beats[1].u[15:0], hs + 2);
    end
    n_cmp++;
    if (pkt_cnt !== 16'd1) begin n_err++; $display("FAIL single_pkt_cnt: got %0d exp 1", pkt_cnt); end
  endtask

  task automatic test_four_beats();
    int unsigned    hs;
    int unsigned    bad;
    logic [4*W-1:0] dat;
    for (int k = 0; k < 4*W/32; k++) dat[32*k +: 32] = $urandom;
    beats.delete();
    send(5'd4, 3'd7, 8'hFF, 2'd3, dat, hs);
    wait_tlast(n_tlast + 1);
    n_cmp++;
    if (beats.size() != 5) begin
      n_err++;
      $display("FAIL four_nbeats: got %0d beats exp 5", beats.size());
      return;
    end
    n_cmp++;
    if (beats[0].d[31:0] !== 32'hFF27F2F1) begin n_err++; $display("FAIL four_hdr: got %h exp ff27f2f1", beats[0].d[31:0]); end
    n_cmp++;
    if (beats[0].u[15:0] !== 16'd160) begin n_err++; $display("FAIL four_tuser: got %0d exp 160", beats[0].u[15:0]); end
    bad = 0;
    for (int i = 0; i < 5; i++) if (beats[i].c != hs + 1 + i) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL four_contiguous: %0d beats off-cycle, exp 0", bad); end
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (beats[i].d !== dat[(i-1)*W +: W] || beats[i].l !== (i == 4)) begin
        n_err++;
        $display("FAIL four_payload%0d: tdata=%h tlast=%b exp %h/%b", i, beats[i].d, beats[i].l, dat[(i-1)*W +: W], (i == 4));
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned hs;
    int unsigned t_last;
    int unsigned bad;
    int unsigned t = 0;
    int unsigned base = n_tlast;
    beats.delete();
    while (req_ready !== 1'b1 && t < 50) begin tick(); t++; end
    req_stage_id = 5'd1; req_mod_id = 3'd0; req_index = 8'h10; req_nbeats = 2'd1;
    req_data  = {4{256'h1234}};
    req_valid = 1'b1;
    hs = cyc;
    tick();
    // second request held waiting while the first runs
    req_stage_id = 5'd3; req_mod_id = 3'd2; req_index = 8'h20; req_nbeats = 2'd0;
    req_data  = {4{256'h5678}};
    wait_tlast(base + 2);
    req_valid = 1'b0;
    n_cmp++;
    if (beats.size() != 5) begin
      n_err++;
      $display("FAIL b2b_nbeats: got %0d beats exp 5", beats.size());
      return;
    end
    t_last = beats[2].c;
    n_cmp++;
    if (beats[0].c != hs + 1 || beats[2].l !== 1'b1) begin
      n_err++; $display("FAIL b2b_first: hdr cyc=%0d tlast=%b exp %0d/1", beats[0].c, beats[2].l, hs + 1);
    end
    n_cmp++;
    if (beats[3].c != t_last + IPG + 2) begin
      n_err++; $display("FAIL b2b_gap: 2nd hdr cyc=%0d exp %0d", beats[3].c, t_last + IPG + 2);
    end
    n_cmp++;
    if (beats[3].d[31:0] !== 32'h201AF2F1 || beats[4].d !== 256'h5678 || beats[4].l !== 1'b1) begin
      n_err++; $display("FAIL b2b_second: hdr=%h data=%h tlast=%b exp 201af2f1/5678/1", beats[3].d[31:0], beats[4].d, beats[4].l);
    end
    bad = 0;
    for (int unsigned c = hs + 1; c <= t_last + IPG; c++) if (rdy_log[c] != 1'b0) bad++;
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL b2b_ready_low: %0d cycles ready=1, exp 0", bad); end
    n_cmp++;
    if (rdy_log[t_last + IPG + 1] != 1'b1) begin
      n_err++; $display("FAIL b2b_ready_idle: got %b exp 1", rdy_log[t_last + IPG + 1]);
    end
    n_cmp++;
    if (pkt_cnt !== 16'd4) begin n_err++; $display("FAIL b2b_pkt_cnt: got %0d exp 4", pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    int unsigned hs;
    int unsigned tl0 = n_tlast;
    send(5'd0, 3'd0, 8'h01, 2'd3, {4{256'hBEEF}}, hs);
    tick();
    tick();
    n_cmp++;
    if (c_m_axis_tvalid !== 1'b1 || c_m_axis_tlast !== 1'b0) begin
      n_err++; $display("FAIL mid_pre: tvalid=%b tlast=%b exp 1/0", c_m_axis_tvalid, c_m_axis_tlast);
    end
    areset = 1'b1;
    tick();
    n_cmp++;
    if (c_m_axis_tvalid !== 1'b0 || c_m_axis_tlast !== 1'b0) begin
      n_err++; $display("FAIL mid_tvalid: tvalid=%b tlast=%b exp 0/0", c_m_axis_tvalid, c_m_axis_tlast);
    end
    n_cmp++;
    if (pkt_cnt !== 16'd0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_state: pkt_cnt=%0d ready=%b busy=%b exp 0/1/0", pkt_cnt, req_ready, busy);
    end
    areset = 1'b0;
    repeat (8) tick();
    n_cmp++;
    if (n_tlast != tl0 || c_m_axis_tvalid !== 1'b0) begin
      n_err++; $display("FAIL mid_no_tlast: tlast count=%0d tvalid=%b exp %0d/0", n_tlast, c_m_axis_tvalid, tl0);
    end
  endtask

  task automatic test_clamp_nogap();
    for (int k = 0; k < 4; k++) r2_data[k*W +: W] = {8{32'hC0DE0000 + k}};
    r2_nbeats = 2'd3;
    r2_valid  = 1'b1;
    tick();
    r2_valid  = 1'b0;
    n_cmp++;
    if (o2_tvalid !== 1'b1 || o2_tuser[15:0] !== 16'd96 || o2_tdata[31:0] !== 32'h3309F2F1) begin
      n_err++; $display("FAIL clamp_hdr: tvalid=%b len=%0d hdr=%h exp 1/96/3309f2f1", o2_tvalid, o2_tuser[15:0], o2_tdata[31:0]);
    end
    tick();
    n_cmp++;
    if (o2_tdata !== r2_data[W-1:0] || o2_tlast !== 1'b0) begin
      n_err++; $display("FAIL clamp_beat0: tdata=%h tlast=%b exp %h/0", o2_tdata, o2_tlast, r2_data[W-1:0]);
    end
    tick();
    n_cmp++;
    if (o2_tdata !== r2_data[2*W-1:W] || o2_tlast !== 1'b1) begin
      n_err++; $display("FAIL clamp_beat1: tdata=%h tlast=%b exp %h/1", o2_tdata, o2_tlast, r2_data[2*W-1:W]);
    end
    tick();
    n_cmp++;
    if (o2_tvalid !== 1'b0 || r2_ready !== 1'b1 || o2_pkt_cnt !== 16'd1) begin
      n_err++; $display("FAIL nogap_idle: tvalid=%b ready=%b pkt_cnt=%0d exp 0/1/1", o2_tvalid, r2_ready, o2_pkt_cnt);
    end
    r2_nbeats = 2'd0;
    r2_valid  = 1'b1;
    tick();
    r2_valid  = 1'b0;
    n_cmp++;
    if (o2_tvalid !== 1'b1 || o2_tuser[15:0] !== 16'd64) begin
      n_err++; $display("FAIL nogap_hdr: tvalid=%b len=%0d exp 1/64", o2_tvalid, o2_tuser[15:0]);
    end
    repeat (3) tick();
  endtask

  task automatic test_seq();
    int unsigned hs;
    logic [7:0]  exp_seq;
    areset = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    tick();
    for (int i = 0; i < 257; i++) begin
      beats.delete();
      send(5'd1, 3'd1, 8'(i), 2'd0, '0, hs);
      wait_tlast(n_tlast + 1);
`ifdef CTRL_GEN_SEQNUM_EN
      exp_seq = 8'(i);
`else
      exp_seq = 8'h00;
`endif
      n_cmp++;
      if (beats.size() < 1 || beats[0].d[39:32] !== exp_seq) begin
        n_err++;
        $display("FAIL seq_%0d: got %h exp %h", i, (beats.size() > 0) ? beats[0].d[39:32] : 8'hxx, exp_seq);
      end
    end
    n_cmp++;
    if (pkt_cnt !== 16'd257) begin n_err++; $display("FAIL seq_pkt_cnt: got %0d exp 257", pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_four_beats();
    test_back_to_back();
    test_reset_mid();
    test_clamp_nogap();
    test_seq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
